// File: rtl/cdc_handshake_rx.sv
// Responder side of a 4-phase req/ack bundled-data clock-domain crossing.
// Synchronizes req_in, captures data_in once, and offers it via valid/ready before acknowledging.
module cdc_handshake_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ack_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  xfer_cnt,
  output logic                  proto_err
);

  typedef enum logic [1:0] {IDLE, VALID, ACK} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   capture, accept, err_set;

  // Only the request level crosses; data_in is stable by the bundled-data rule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    accept    = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: if (req_s) begin
        capture   = 1'b1;
        state_nxt = VALID;
      end
      VALID: begin
        // Early withdrawal is flagged but the offered word still completes.
        if (!req_s) err_set = 1'b1;
        if (data_ready) begin
          accept    = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: if (!req_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ack_out and data_valid are dedicated flops so nothing decoded reaches the other domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ack_out    <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
      xfer_cnt   <= '0;
      proto_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      ack_out    <= (state_nxt == ACK);
      data_valid <= (state_nxt == VALID);
      if (capture) data_out  <= data_in;
      if (accept)  xfer_cnt  <= xfer_cnt + CNT_WIDTH'(1);
      if (err_set) proto_err <= 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Bench for cdc_handshake_rx: directed vector table, corner sequences, and a
// randomized slow-initiator / random-ready run checked against a scoreboard.
module tb_cdc_handshake_rx;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0, sclk = 1'b0;
  logic          rst_n, req_in, data_ready;
  logic [DW-1:0] data_in, data_out;
  logic          ack_out, data_valid, busy, proto_err;
  logic [CW-1:0] xfer_cnt;

  int errs = 0, checks = 0;

  cdc_handshake_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .data_in(data_in),
    .ack_out(ack_out), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .busy(busy), .xfer_cnt(xfer_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;
  initial begin #7; forever #15 sclk = ~sclk; end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One transfer with fixed timing: request, wait cycles of backpressure, accept, release.
  task automatic xfer(input logic [DW-1:0] w, input int rwait, input int exp_cnt);
    data_in = w; data_ready = 1'b0; req_in = 1'b1;
    step(); chk("lat_e0", data_valid, 0);
    step(); chk("lat_e1", data_valid, 0);
    step(); chk("valid_rise", data_valid, 1); chk("data_cap", data_out, w); chk("busy_on", busy, 1);
    for (int i = 0; i < rwait; i++) begin
      step(); chk("bp_valid", data_valid, 1); chk("bp_ack", ack_out, 0); chk("bp_data", data_out, w);
    end
    data_ready = 1'b1;
    step(); chk("acc_valid", data_valid, 0); chk("acc_ack", ack_out, 1); chk("acc_cnt", xfer_cnt, exp_cnt);
    req_in = 1'b0; data_ready = 1'b0;
    step(); chk("rel_ack0", ack_out, 1);
    step(); chk("rel_ack1", ack_out, 1);
    step(); chk("rel_ack_low", ack_out, 0); chk("rel_busy", busy, 0); chk("hold_data", data_out, w);
  endtask

  typedef struct {
    logic [DW-1:0] word;
    int            rwait;
    int            exp_cnt;
  } vec_t;

  vec_t    vecs[4];
  logic [DW-1:0] exp_q[$];
  int      acc;
  bit      init_done;
  localparam int NRAND = 20;

  initial begin
    vecs[0] = '{8'hA5, 0, 1};
    vecs[1] = '{8'h3C, 10, 2};
    vecs[2] = '{8'h00, 3, 3};
    vecs[3] = '{8'hFF, 1, 4};

    // Reset defaults with req already high
    rst_n = 1'b0; req_in = 1'b1; data_in = 8'h5A; data_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_ack", ack_out, 0); chk("rst_valid", data_valid, 0); chk("rst_data", data_out, 0);
    chk("rst_cnt", xfer_cnt, 0); chk("rst_busy", busy, 0); chk("rst_perr", proto_err, 0);
    rst_n = 1'b1;
    step(); chk("post_rst_e0", data_valid, 0);
    step(); chk("post_rst_e1", data_valid, 0);
    step(); chk("post_rst_valid", data_valid, 1); chk("post_rst_data", data_out, 8'h5A);
    rst_n = 1'b0; #1;
    chk("rst_async_valid", data_valid, 0); chk("rst_async_data", data_out, 0);
    req_in = 1'b0; step(); rst_n = 1'b1; step();

    foreach (vecs[i]) xfer(vecs[i].word, vecs[i].rwait, vecs[i].exp_cnt);

    // Request withdrawn while the word is still offered
    data_in = 8'h77; req_in = 1'b1;
    repeat (3) step();
    chk("pv_valid", data_valid, 1);
    req_in = 1'b0;
    step(); chk("pv_perr_early", proto_err, 0);
    step(); chk("pv_perr_early2", proto_err, 0);
    step(); chk("pv_perr_set", proto_err, 1); chk("pv_still_valid", data_valid, 1);
    data_ready = 1'b1;
    step(); chk("pv_ack", ack_out, 1); chk("pv_cnt", xfer_cnt, 5);
    data_ready = 1'b0;
    step(); chk("pv_ack_pulse", ack_out, 0); chk("pv_idle", busy, 0);
    repeat (3) step();
    chk("pv_sticky", proto_err, 1); chk("pv_hold", data_out, 8'h77);

    // Counter wrap, then reset while acknowledging
    rst_n = 1'b0; #1; chk("wr_perr_clr", proto_err, 0);
    step(); rst_n = 1'b1; step();
    for (int i = 0; i < 17; i++) xfer(DW'(8'h10 + i), 0, (i + 1) % 16);
    chk("wrap_cnt", xfer_cnt, 1);
    data_in = 8'hE1; req_in = 1'b1; data_ready = 1'b1;
    repeat (4) step();
    chk("mid_ack", ack_out, 1); chk("mid_cnt", xfer_cnt, 2);
    rst_n = 1'b0; #1;
    chk("mid_rst_ack", ack_out, 0); chk("mid_rst_cnt", xfer_cnt, 0); chk("mid_rst_busy", busy, 0);
    req_in = 1'b0; data_ready = 1'b0;
    step(); rst_n = 1'b1; step();

    // Randomized: 3x-slower initiator, random consumer ready, scoreboard model
    acc = 0; init_done = 1'b0;
    fork
      begin
        int n;
        logic [DW-1:0] w;
        for (int i = 0; i < NRAND; i++) begin
          w = (i < 5) ? DW'(i + 1) : DW'($urandom_range(0, 255));
          @(posedge sclk); data_in = w; exp_q.push_back(w);
          @(posedge sclk); req_in = 1'b1;
          n = 0;
          while (ack_out !== 1'b1 && n < 60) begin @(posedge sclk); n++; end
          chk("rand_ack_rise_bound", n < 60, 1);
          if (n >= 60) break;
          req_in = 1'b0;
          n = 0;
          while (ack_out !== 1'b0 && n < 60) begin @(posedge sclk); n++; end
          chk("rand_ack_fall_bound", n < 60, 1);
          if (n >= 60) break;
        end
        init_done = 1'b1;
      end
      begin
        int cyc = 0;
        while (!init_done && cyc < 8000) begin
          @(negedge clk); cyc++;
          chk("rand_cnt", xfer_cnt, acc % 16);
          data_ready = 1'($urandom_range(0, 1));
          if (data_valid && data_ready) begin
            if (exp_q.size() == 0) chk("rand_spurious", 1, 0);
            else chk("rand_data", data_out, exp_q.pop_front());
            acc++;
          end
        end
        chk("rand_consumer_bound", cyc < 8000, 1);
      end
    join
    @(negedge clk);
    chk("rand_total", acc, NRAND);
    chk("rand_final_cnt", xfer_cnt, NRAND % 16);
    chk("rand_perr", proto_err, 0);
    chk("rand_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
